alu_issue_ctrl: RTL

Instruction-side issue controller that drives the tiny16 ALU. Accepts 16-bit instruction words over a valid/ready handshake, decodes them, reads operands from an internal 8×16 register file, and drives `opcode`/`ar_flag`/`src1`/`src2`/`out_en` into the ALU. It then captures the ALU `out`/`flags` and writes the result back, giving the ALU its producer/consumer on both its input and output sides. It sits between instruction fetch and the existing ALU.

---
 rtl/alu_issue_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: instruction issue controller in front of the tiny16 ALU.
// Accepts 16-bit instruction words over valid/ready, reads operands from an
// 8x16 register file, drives the ALU and writes its result back.
// Optional feature: define ALU_ISSUE_DIV0_TRAP_EN to reject DIV by zero
// at acceptance (err pulse, no issue) instead of issuing it.
module alu_issue_ctrl #(
  parameter int NREGS = 8,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [15:0]  instr,
  output logic [3:0]   alu_opcode,
  output logic         alu_ar_flag,
  output logic [W-1:0] alu_src1,
  output logic [W-1:0] alu_src2,
  output logic         alu_out_en,
  input  logic [W-1:0] alu_out,
  input  logic [3:0]   alu_flags,
  output logic [3:0]   flags,
  output logic         done,
  output logic         err,
  input  logic [2:0]   dbg_sel,
  output logic [W-1:0] dbg_data
);

  localparam int unsigned LP_NREGS = NREGS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_LOAD
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_rf [NREGS];
  logic [2:0]     r_rd;
  logic [7:0]     r_imm;
  logic [3:0]     r_opcode;
  logic           r_ar;
  logic [W-1:0]   r_src1;
  logic [W-1:0]   r_src2;
  logic           r_out_en;
  logic [3:0]     r_flags;
  logic           r_done;
  logic           r_err;

  logic [3:0]     w_op;
  logic [2:0]     w_rd;
  logic [2:0]     w_rs1;
  logic [2:0]     w_rs2;
  logic [W-1:0]   w_rs1_val;
  logic [W-1:0]   w_rs2_val;
  logic           w_is_alu;
  logic           w_is_ldi;
  logic           w_trap;
  logic           w_hs;

  // Ready only in IDLE and forced low while reset is held.
  assign instr_ready = rst & (r_state == S_IDLE);
  assign w_hs        = instr_valid & instr_ready;

  assign alu_opcode  = r_opcode;
  assign alu_ar_flag = r_ar;
  assign alu_src1    = r_src1;
  assign alu_src2    = r_src2;
  assign alu_out_en  = r_out_en;
  assign flags       = r_flags;
  assign done        = r_done;
  assign err         = r_err;
  assign dbg_data    = r_rf[dbg_sel];

  // Decode the instruction word and fetch operands for the acceptance edge.
  always_comb begin
    w_op      = instr[15:12];
    w_rd      = instr[10:8];
    w_rs1     = instr[7:5];
    w_rs2     = instr[4:2];
    w_rs1_val = r_rf[w_rs1];
    w_rs2_val = r_rf[w_rs2];
    w_is_alu  = (w_op >= 4'd3) && (w_op <= 4'd11);
    w_is_ldi  = (w_op == 4'd1);
`ifdef ALU_ISSUE_DIV0_TRAP_EN
    w_trap    = (w_op == 4'd6) && (w_rs2_val == '0);
`else
    w_trap    = 1'b0;
`endif
  end

  // Issue FSM with registered ALU drive, register-file writeback and pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      for (int unsigned i = 0; i < LP_NREGS; i++) begin
        r_rf[i] <= '0;
      end
      r_rd     <= '0;
      r_imm    <= '0;
      r_opcode <= '0;
      r_ar     <= 1'b0;
      r_src1   <= '0;
      r_src2   <= '0;
      r_out_en <= 1'b0;
      r_flags  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            if (w_is_alu && !w_trap) begin
              r_state  <= S_ISSUE;
              r_opcode <= w_op;
              r_ar     <= instr[11];
              r_src1   <= w_rs1_val;
              r_src2   <= w_rs2_val;
              r_out_en <= 1'b1;
              r_rd     <= w_rd;
            end else if (w_is_ldi) begin
              r_state <= S_LOAD;
              r_rd    <= w_rd;
              r_imm   <= instr[7:0];
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_rf[r_rd] <= alu_out;
          r_flags    <= alu_flags;
          r_done     <= 1'b1;
          r_opcode   <= '0;
          r_ar       <= 1'b0;
          r_src1     <= '0;
          r_src2     <= '0;
          r_out_en   <= 1'b0;
          r_state    <= S_IDLE;
        end
        S_LOAD: begin
          r_rf[r_rd] <= {{(W-8){1'b0}}, r_imm};
          r_done     <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
